coin_credit_unit: RTL and testbench
===================================

Name: coin_credit_unit

Overview:
- Upstream stage of the vending-machine IDLE/ACCEPT/CHECK controller.
- Accepts denominated coins, accumulates credit and rejects coins that would overflow.
- Issues the one-cycle `coin` and `check` strobes that drive the controller.
- After a vend, or on cancel, pays back the remaining credit as change, largest denomination first, over a ready/valid handshake to the coin dispenser.

Parameters:
- VAL0, 5, value of coin code 0 (smallest denomination; all prices are multiples of VAL0)
- VAL1, 10, value of coin code 1
- VAL2, 25, value of coin code 2
- VAL3, 100, value of coin code 3
- MAX_CREDIT, 250, credit ceiling; must be ≤ 255

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle strobe: a coin is present
- coin_type  in  2  denomination code of the presented coin
- price  in  8  price of the selected item; sampled on accepted select
- select  in  1  purchase request
- cancel  in  1  abort; refund all credit
- vend_done  in  1  downstream finished dispensing the item
- refund_ready  in  1  change dispenser can take a coin
- coin_pulse  out  1  one-cycle strobe per accepted coin (feeds controller `coin`)
- check_pulse  out  1  one-cycle strobe on a valid purchase (feeds controller `check`)
- reject  out  1  one-cycle strobe: presented coin returned, not credited
- credit  out  8  current credit, registered
- sufficient  out  1  registered; high when credit ≥ price in ACTIVE
- refund_valid  out  1  change coin offered
- refund_coin  out  2  denomination code of the offered change coin
- busy  out  1  high in VEND_WAIT or REFUND

Behaviour:

Reset:
- On reset: state IDLE, credit 0, price_q 0, all outputs 0.
- Reset asserted mid-REFUND or mid-VEND_WAIT discards the credit; no further refund coins are offered.

States: IDLE, ACTIVE, VEND_WAIT, REFUND.
- Encoding: IDLE 0, ACTIVE 1, VEND_WAIT 2, REFUND 3.

Coin acceptance (IDLE and ACTIVE only):
- Coin is accepted when coin_valid and credit + VALn ≤ MAX_CREDIT. Sum is computed at 9 bits; there is no wrap.
- Accepted coin: at the next edge, credit += VALn, coin_pulse = 1 for one cycle, state = ACTIVE.
- Coin that would exceed MAX_CREDIT: credit unchanged, reject = 1 for one cycle.
- Latency is 1 cycle from coin_valid to coin_pulse/credit update.
- coin_valid in VEND_WAIT or REFUND: reject = 1, credit unchanged.

Select (ACTIVE only):
- select with credit ≥ price: price_q ← price, check_pulse = 1 for one cycle, state → VEND_WAIT.
- select with credit < price: ignored; no output.
- select in IDLE: ignored.

Priority in ACTIVE, same cycle:
- cancel > coin_valid > select.
- cancel with coin_valid: coin is rejected, state → REFUND.
- coin_valid with select: coin is processed, select is dropped and must be reasserted.

VEND_WAIT:
- Waits for vend_done; select and cancel are ignored.
- On vend_done: credit ← credit − price_q.
- Result 0 → IDLE; otherwise → REFUND.

REFUND:
- refund_valid = 1 while credit ≥ VAL0.
- refund_coin = highest code n with VALn ≤ credit.
- On refund_valid && refund_ready: credit −= VALn at that edge, and refund_coin is recomputed for the next cycle.
- refund_valid low with refund_ready high: no effect.
- refund_coin must hold stable while refund_valid is high and refund_ready is low.
- Credit reaching 0 → IDLE; refund_valid drops in the same cycle the state becomes IDLE.
- If 0 < credit < VAL0: credit is forfeited (set to 0) and state → IDLE in one cycle.

sufficient:
- Registered; equals (credit ≥ price) in ACTIVE and 0 in all other states.
- It lags a price change by one cycle.

Decomposition:
- Package vend_pkg holds:
  - state enum encoding (IDLE 0, ACTIVE 1, VEND_WAIT 2, REFUND 3)
  - coin code constants (COIN_5 0, COIN_10 1, COIN_25 2, COIN_100 3)
  - credit width 8
- Sub-module change_picker: combinational; credit in → {refund_coin, value, has_coin} out. Keeps the REFUND datapath separate from the FSM.

Test Plan:
1. Reset, then coins code 2, code 2, code 1 on separate cycles → three coin_pulse strobes; credit 25, 50, 60; state ACTIVE.
2. Credit 60, price 50, select → check_pulse one cycle; busy = 1; vend_done → credit 10; refund_valid, refund_coin 1; with refund_ready high → credit 0, IDLE, busy 0.
3. Credit 200, insert code 3 → reject one cycle, credit stays 200; insert code 2 → credit 225.
4. Credit 40, price 50, select → no check_pulse, sufficient 0; coin_valid (code 0, value 5) and select in the same cycle → credit 45, no check_pulse.
5. Credit 140, cancel with coin_valid (code 3, value 100) in the same cycle → reject; refund codes 3, 2, 1, 0 in order; hold refund_ready low 3 cycles mid-sequence → refund_coin stable, credit frozen.
6. Assert rst asynchronously mid-REFUND (credit 35) → credit 0, refund_valid 0, state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine coin path.
// State encoding, coin codes and the credit width live here.
package vend_pkg;

    localparam int CREDIT_W = 8;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        VEND_WAIT = 2'd2,
        REFUND    = 2'd3
    } state_t;

    localparam logic [1:0] COIN_5   = 2'd0;
    localparam logic [1:0] COIN_10  = 2'd1;
    localparam logic [1:0] COIN_25  = 2'd2;
    localparam logic [1:0] COIN_100 = 2'd3;

    // Busy means the unit owns the credit and will not take coins.
    function automatic logic is_busy(input state_t s);
        return (s == VEND_WAIT) || (s == REFUND);
    endfunction

endpackage

// File: rtl/coin_credit_unit_change_picker.sv
// Change picker: largest denomination that fits in the credit.
// Purely combinational; feeds the REFUND datapath.
module change_picker
    import vend_pkg::*;
#(
    parameter int VAL0 = 5,
    parameter int VAL1 = 10,
    parameter int VAL2 = 25,
    parameter int VAL3 = 100
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          refund_coin,
    output logic [CREDIT_W-1:0] value,
    output logic                has_coin
);

    localparam logic [CREDIT_W-1:0] V0 = CREDIT_W'(VAL0);
    localparam logic [CREDIT_W-1:0] V1 = CREDIT_W'(VAL1);
    localparam logic [CREDIT_W-1:0] V2 = CREDIT_W'(VAL2);
    localparam logic [CREDIT_W-1:0] V3 = CREDIT_W'(VAL3);

    // Largest-first selection; below VAL0 nothing can be paid out.
    always_comb begin
        refund_coin = COIN_5;
        value       = V0;
        has_coin    = 1'b0;
        if (credit >= V3) begin
            refund_coin = COIN_100;
            value       = V3;
            has_coin    = 1'b1;
        end else if (credit >= V2) begin
            refund_coin = COIN_25;
            value       = V2;
            has_coin    = 1'b1;
        end else if (credit >= V1) begin
            refund_coin = COIN_10;
            value       = V1;
            has_coin    = 1'b1;
        end else if (credit >= V0) begin
            refund_coin = COIN_5;
            value       = V0;
            has_coin    = 1'b1;
        end
    end

endmodule

// File: rtl/coin_credit_unit.sv
// Coin credit unit: accepts coins, strobes the controller,
// and pays change back largest coin first after vend or cancel.
module coin_credit_unit
    import vend_pkg::*;
#(
    parameter int VAL0       = 5,
    parameter int VAL1       = 10,
    parameter int VAL2       = 25,
    parameter int VAL3       = 100,
    parameter int MAX_CREDIT = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic [CREDIT_W-1:0] price,
    input  logic                select,
    input  logic                cancel,
    input  logic                vend_done,
    input  logic                refund_ready,
    output logic                coin_pulse,
    output logic                check_pulse,
    output logic                reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                sufficient,
    output logic                refund_valid,
    output logic [1:0]          refund_coin,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_t        state, state_n;
    credit_t       credit_n;
    credit_t       price_q, price_q_n;
    logic          coin_pulse_n;
    logic          check_pulse_n;
    logic          reject_n;
    logic          sufficient_n;

    credit_t       coin_val;
    logic [CREDIT_W:0] sum;
    logic          fits;

    logic [1:0]    pick_coin;
    credit_t       pick_val;
    logic          pick_has;

    change_picker #(
        .VAL0 (VAL0),
        .VAL1 (VAL1),
        .VAL2 (VAL2),
        .VAL3 (VAL3)
    ) u_pick (
        .credit      (credit),
        .refund_coin (pick_coin),
        .value       (pick_val),
        .has_coin    (pick_has)
    );

    // Denomination lookup and overflow test at one extra bit.
    always_comb begin
        coin_val = CREDIT_W'(VAL0);
        unique case (coin_type)
            COIN_5:   coin_val = CREDIT_W'(VAL0);
            COIN_10:  coin_val = CREDIT_W'(VAL1);
            COIN_25:  coin_val = CREDIT_W'(VAL2);
            COIN_100: coin_val = CREDIT_W'(VAL3);
            default:  coin_val = CREDIT_W'(VAL0);
        endcase
        sum  = {1'b0, credit} + {1'b0, coin_val};
        fits = (sum <= MAX_C);
    end

    // Next-state, credit and strobe logic.
    always_comb begin
        state_n       = state;
        credit_n      = credit;
        price_q_n     = price_q;
        coin_pulse_n  = 1'b0;
        check_pulse_n = 1'b0;
        reject_n      = 1'b0;
        unique case (state)
            IDLE, ACTIVE: begin
                if ((state == ACTIVE) && cancel) begin
                    reject_n = coin_valid;
                    state_n  = REFUND;
                end else if (coin_valid) begin
                    if (fits) begin
                        credit_n     = sum[CREDIT_W-1:0];
                        coin_pulse_n = 1'b1;
                        state_n      = ACTIVE;
                    end else begin
                        reject_n = 1'b1;
                    end
                end else if ((state == ACTIVE) && select
                             && (credit >= price)) begin
                    price_q_n     = price;
                    check_pulse_n = 1'b1;
                    state_n       = VEND_WAIT;
                end
            end
            VEND_WAIT: begin
                reject_n = coin_valid;
                if (vend_done) begin
                    credit_n = credit - price_q;
                    state_n  = (credit_n == '0) ? IDLE : REFUND;
                end
            end
            REFUND: begin
                reject_n = coin_valid;
                if (pick_has) begin
                    if (refund_ready) begin
                        credit_n = credit - pick_val;
                        if (credit_n == '0) state_n = IDLE;
                    end
                end else begin
                    credit_n = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        sufficient_n = (state_n == ACTIVE) && (credit_n >= price);
    end

    // State, credit and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            price_q     <= '0;
            coin_pulse  <= 1'b0;
            check_pulse <= 1'b0;
            reject      <= 1'b0;
            sufficient  <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            price_q     <= price_q_n;
            coin_pulse  <= coin_pulse_n;
            check_pulse <= check_pulse_n;
            reject      <= reject_n;
            sufficient  <= sufficient_n;
        end
    end

    // Change offer follows the registered state so reset kills it at once.
    always_comb begin
        refund_valid = (state == REFUND) && pick_has;
        refund_coin  = refund_valid ? pick_coin : COIN_5;
        busy         = is_busy(state);
    end

endmodule

// File: tb/tb_coin_credit_unit.sv
// Self-checking bench for coin_credit_unit.
// Directed scenarios plus random traffic against a behavioural model.
module tb_coin_credit_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic [7:0] price = 8'd0;
    logic       select = 1'b0;
    logic       cancel = 1'b0;
    logic       vend_done = 1'b0;
    logic       refund_ready = 1'b0;
    logic       coin_pulse;
    logic       check_pulse;
    logic       reject;
    logic [7:0] credit;
    logic       sufficient;
    logic       refund_valid;
    logic [1:0] refund_coin;
    logic       busy;

    coin_credit_unit dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .price        (price),
        .select       (select),
        .cancel       (cancel),
        .vend_done    (vend_done),
        .refund_ready (refund_ready),
        .coin_pulse   (coin_pulse),
        .check_pulse  (check_pulse),
        .reject       (reject),
        .credit       (credit),
        .sufficient   (sufficient),
        .refund_valid (refund_valid),
        .refund_coin  (refund_coin),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int vals [4] = '{5, 10, 25, 100};

    // Model: mode 0 idle, 1 collecting, 2 vending, 3 paying change.
    int m_mode, m_cr, m_pq;
    int e_cp, e_chk, e_rej, e_suf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int best_coin(input int c);
        for (int i = 3; i >= 0; i--)
            if (vals[i] <= c) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cr = 0; m_pq = 0;
        e_cp = 0; e_chk = 0; e_rej = 0; e_suf = 0;
    endtask

    task automatic check_all();
        bit rv;
        rv = (m_mode == 3) && (m_cr >= vals[0]);
        chk("credit",       credit,       m_cr);
        chk("coin_pulse",   coin_pulse,   e_cp);
        chk("check_pulse",  check_pulse,  e_chk);
        chk("reject",       reject,       e_rej);
        chk("sufficient",   sufficient,   e_suf);
        chk("busy",         busy,         int'(m_mode >= 2));
        chk("refund_valid", refund_valid, int'(rv));
        chk("refund_coin",  refund_coin,  rv ? best_coin(m_cr) : 0);
    endtask

    // Apply inputs at a falling edge, advance the model, check next fall.
    task automatic step(input bit cv, input int ct, input int pr,
                        input bit sel, input bit can, input bit vd,
                        input bit rr);
        int nm, nc;
        coin_valid   = cv;
        coin_type    = 2'(ct);
        price        = 8'(pr);
        select       = sel;
        cancel       = can;
        vend_done    = vd;
        refund_ready = rr;
        nm = m_mode; nc = m_cr;
        e_cp = 0; e_chk = 0; e_rej = 0;
        if (m_mode <= 1) begin
            if (m_mode == 1 && can) begin
                e_rej = cv;
                nm = 3;
            end else if (cv) begin
                if (m_cr + vals[ct] <= 250) begin
                    nc = m_cr + vals[ct];
                    e_cp = 1;
                    nm = 1;
                end else begin
                    e_rej = 1;
                end
            end else if (m_mode == 1 && sel && m_cr >= pr) begin
                m_pq = pr;
                e_chk = 1;
                nm = 2;
            end
        end else if (m_mode == 2) begin
            e_rej = cv;
            if (vd) begin
                nc = m_cr - m_pq;
                nm = (nc == 0) ? 0 : 3;
            end
        end else begin
            e_rej = cv;
            if (m_cr >= vals[0]) begin
                if (rr) begin
                    nc = m_cr - vals[best_coin(m_cr)];
                    if (nc == 0) nm = 0;
                end
            end else begin
                nc = 0;
                nm = 0;
            end
        end
        m_mode = nm;
        m_cr   = nc;
        e_suf  = (nm == 1) && (nc >= pr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        coin_valid = 0; coin_type = 0; select = 0; cancel = 0;
        vend_done = 0; refund_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int cv, sel, can, vd, rr, pr;
        model_reset();
        @(negedge clk);
        do_reset();

        // Three coins accumulate.
        step(1, 2, 50, 0, 0, 0, 0);
        step(1, 2, 50, 0, 0, 0, 0);
        step(1, 1, 50, 0, 0, 0, 0);
        chk("t1_credit", credit, 60);

        // Purchase, vend, one change coin back.
        step(0, 0, 50, 1, 0, 0, 0);
        chk("t2_check", check_pulse, 1);
        step(0, 0, 50, 0, 0, 1, 0);
        chk("t2_after_vend", credit, 10);
        chk("t2_coin", refund_coin, 1);
        step(0, 0, 50, 0, 0, 0, 1);
        chk("t2_busy", busy, 0);

        // Overflow reject at the ceiling.
        do_reset();
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        chk("t3_reject", reject, 1);
        step(1, 2, 0, 0, 0, 0, 0);
        chk("t3_credit", credit, 225);

        // Insufficient select, then coin beats select.
        do_reset();
        step(1, 2, 50, 0, 0, 0, 0);
        step(1, 1, 50, 0, 0, 0, 0);
        step(1, 0, 50, 0, 0, 0, 0);
        step(0, 0, 50, 1, 0, 0, 0);
        chk("t4_nochk", check_pulse, 0);
        step(1, 0, 50, 1, 0, 0, 0);
        chk("t4_credit", credit, 45);

        // Cancel wins over coin, then staged refund with a stall.
        do_reset();
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 1, 0, 0);
        chk("t5_reject", reject, 1);
        chk("t5_first", refund_coin, 3);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t5_stall", refund_coin, 2);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t5_done", credit, 0);

        // Asynchronous reset in the middle of a refund.
        do_reset();
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t6_rv", refund_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_credit", credit, 0);
        chk("t6_rv0", refund_valid, 0);
        chk("t6_busy", busy, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cv  = ($urandom_range(0, 9) < 3);
                sel = ($urandom_range(0, 9) < 2);
                can = ($urandom_range(0, 19) == 0);
                vd  = ($urandom_range(0, 9) < 3);
                rr  = ($urandom_range(0, 9) < 6);
                pr  = 5 * $urandom_range(1, 50);
                step(cv[0], $urandom_range(0, 3), pr, sel[0], can[0],
                     vd[0], rr[0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
